// File: rtl/firmware_loader_pkg.sv
// Shared types and constants for the boot-time firmware loader.
package firmware_loader_pkg;

    typedef logic [7:0] data_t;

    localparam int unsigned FirmwareSize   = 16384;
    localparam data_t       LoaderMagic    = 8'hA5;
    localparam int unsigned NumVectorBytes = 6;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_LO  = 3'd1,
        ST_LEN_HI  = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_VECTORS = 3'd4,
        ST_CHECK   = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERROR   = 3'd7
    } firmware_loader_state_t;

    // Loader stops accepting bytes once it has reached a final verdict.
    function automatic logic is_terminal(firmware_loader_state_t s);
        return (s == ST_DONE) || (s == ST_ERROR);
    endfunction

endpackage

// File: rtl/firmware_loader.sv
// Parses a framed firmware image from the host byte stream, writes payload
// and vector bytes into memory, verifies the checksum and releases the CPU.
module firmware_loader
    import firmware_loader_pkg::*;
#(
    parameter int unsigned FIRMWARE_SIZE = FirmwareSize,
    parameter int unsigned ADDR_W        = $clog2(FIRMWARE_SIZE)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              boot_skip_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic              wr_en_o,
    output logic              wr_vector_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o,
    output logic              cpu_rst_o,
    output logic              done_o,
    output logic              error_o
);

    // One extra bit so a full-size payload count terminates without wrapping.
    localparam int unsigned CNT_W = ADDR_W + 1;

    firmware_loader_state_t r_state, w_state_next;

    data_t             r_len_lo,  w_len_lo_next;
    logic [CNT_W-1:0]  r_len,     w_len_next;
    logic [CNT_W-1:0]  r_pay_cnt, w_pay_cnt_next;
    logic [2:0]        r_vec_cnt, w_vec_cnt_next;
    data_t             r_sum,     w_sum_next;

    logic              r_rx_ready;
    logic              r_wr_en,     w_wr_en_next;
    logic              r_wr_vector, w_wr_vector_next;
    logic [ADDR_W-1:0] r_wr_addr,   w_wr_addr_next;
    data_t             r_wr_data,   w_wr_data_next;
    logic              r_cpu_rst;
    logic              r_done;
    logic              r_error;

    logic              w_xfer;
    logic [15:0]       w_len_full;
    logic [CNT_W-1:0]  w_pay_inc;
    data_t             w_sum_add;

    assign w_xfer     = rx_valid_i & r_rx_ready;
    assign w_len_full = {rx_data_i, r_len_lo};
    assign w_pay_inc  = r_pay_cnt + CNT_W'(1);
    assign w_sum_add  = r_sum + rx_data_i;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, counter, checksum and write-port decode.
    always_comb begin
        w_state_next     = r_state;
        w_len_lo_next    = r_len_lo;
        w_len_next       = r_len;
        w_pay_cnt_next   = r_pay_cnt;
        w_vec_cnt_next   = r_vec_cnt;
        w_sum_next       = r_sum;
        w_wr_en_next     = 1'b0;
        w_wr_vector_next = r_wr_vector;
        w_wr_addr_next   = r_wr_addr;
        w_wr_data_next   = r_wr_data;

        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    if (rx_data_i == LoaderMagic) begin
                        w_state_next   = ST_LEN_LO;
                        w_sum_next     = '0;
                        w_pay_cnt_next = '0;
                        w_vec_cnt_next = '0;
                    end
                end else if (boot_skip_i) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_LEN_LO: begin
                if (w_xfer) begin
                    w_len_lo_next = rx_data_i;
                    w_state_next  = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (w_xfer) begin
                    if (32'(w_len_full) > FIRMWARE_SIZE) begin
                        w_state_next = ST_ERROR;
                    end else if (w_len_full == 16'd0) begin
                        w_state_next = ST_VECTORS;
                    end else begin
                        w_len_next   = CNT_W'(w_len_full);
                        w_state_next = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (w_xfer) begin
                    w_wr_en_next     = 1'b1;
                    w_wr_vector_next = 1'b0;
                    w_wr_addr_next   = r_pay_cnt[ADDR_W-1:0];
                    w_wr_data_next   = rx_data_i;
                    w_sum_next       = w_sum_add;
                    w_pay_cnt_next   = w_pay_inc;
                    if (w_pay_inc == r_len) begin
                        w_state_next = ST_VECTORS;
                    end
                end
            end
            ST_VECTORS: begin
                if (w_xfer) begin
                    w_wr_en_next     = 1'b1;
                    w_wr_vector_next = 1'b1;
                    w_wr_addr_next   = ADDR_W'(r_vec_cnt);
                    w_wr_data_next   = rx_data_i;
                    w_sum_next       = w_sum_add;
                    w_vec_cnt_next   = r_vec_cnt + 3'd1;
                    if (r_vec_cnt == 3'(NumVectorBytes - 1)) begin
                        w_state_next = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (w_xfer) begin
                    w_sum_next   = w_sum_add;
                    w_state_next = (w_sum_add == 8'd0) ? ST_DONE : ST_ERROR;
                end
            end
            ST_DONE, ST_ERROR: begin
                w_state_next = r_state;
            end
            default: begin
                w_state_next = ST_ERROR;
            end
        endcase
    end

    // Datapath and registered outputs; status outputs track the next state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_len_lo    <= '0;
            r_len       <= '0;
            r_pay_cnt   <= '0;
            r_vec_cnt   <= '0;
            r_sum       <= '0;
            r_rx_ready  <= 1'b1;
            r_wr_en     <= 1'b0;
            r_wr_vector <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_cpu_rst   <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_len_lo    <= w_len_lo_next;
            r_len       <= w_len_next;
            r_pay_cnt   <= w_pay_cnt_next;
            r_vec_cnt   <= w_vec_cnt_next;
            r_sum       <= w_sum_next;
            r_rx_ready  <= ~is_terminal(w_state_next);
            r_wr_en     <= w_wr_en_next;
            r_wr_vector <= w_wr_vector_next;
            r_wr_addr   <= w_wr_addr_next;
            r_wr_data   <= w_wr_data_next;
            r_cpu_rst   <= (w_state_next != ST_DONE);
            r_done      <= (w_state_next == ST_DONE);
            r_error     <= (w_state_next == ST_ERROR);
        end
    end

    assign rx_ready_o  = r_rx_ready;
    assign wr_en_o     = r_wr_en;
    assign wr_vector_o = r_wr_vector;
    assign wr_addr_o   = r_wr_addr;
    assign wr_data_o   = r_wr_data;
    assign cpu_rst_o   = r_cpu_rst;
    assign done_o      = r_done;
    assign error_o     = r_error;

endmodule
